// File: rtl/lsq_pkg.sv
// lsq_pkg: shared types and helpers for the LSQ memory port
package lsq_pkg;
   localparam int XLEN = 32;
   localparam int ROB_IDX_W = 6;
   localparam int TAG_W = 6;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
   typedef struct packed {
      logic                 is_load;
      logic                 is_byte;
      logic [XLEN-1:0]      addr;
      logic [XLEN-1:0]      wdata;
      logic [TAG_W-1:0]     rd_tag;
      logic [ROB_IDX_W-1:0] rob_index;
   } mem_req_t;
   function automatic logic misaligned(input logic is_byte, input logic [1:0] lane);
      return !is_byte && (lane != 2'b00);
   endfunction
   function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] w, input logic [1:0] lane, input logic is_byte);
      return is_byte ? {{(XLEN-8){1'b0}}, w[{lane, 3'b000} +: 8]} : w;
   endfunction
endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: in-order request buffer for the memory port
module mem_req_fifo import lsq_pkg::*; #(
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push_i,
   input  logic [$bits(mem_req_t)-1:0] data_i,
   input  logic                        pop_i,
   output logic [$bits(mem_req_t)-1:0] data_o,
   output logic                        full_o,
   output logic                        empty_o,
   output logic [$clog2(DEPTH):0]      count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [$bits(mem_req_t)-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] count_q;
   // pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_q + AW'(push_i);
         rd_q    <= rd_q + AW'(pop_i);
         count_q <= count_q + CW'(push_i) - CW'(pop_i);
      end
   // payload storage carries no reset
   always_ff @(posedge clk)
      if (push_i) mem_q[wr_q] <= data_i;
   assign data_o  = mem_q[rd_q];
   assign full_o  = count_q == CW'(DEPTH);
   assign empty_o = count_q == '0;
   assign count_o = count_q;
endmodule

// File: rtl/lsq_mem_port.sv
// lsq_mem_port: buffers LSQ requests and runs them one at a time against data memory
module lsq_mem_port import lsq_pkg::*; #(
   parameter int FIFO_DEPTH  = 4,
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_is_load_i,
   input  logic        req_byte_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [5:0]  req_rd_tag_i,
   input  logic [5:0]  req_rob_index_i,
   output logic        mem_en_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_wstrb_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   output logic        load_valid_o,
   output logic [31:0] load_value_o,
   output logic [5:0]  load_rd_tag_o,
   output logic [5:0]  load_rob_index_o,
   output logic        store_done_o,
   output logic [5:0]  store_rob_index_o,
   output logic        misalign_err_o,
   output logic [5:0]  err_rob_index_o
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   mem_req_t req, head, op_q, op_d;
   logic full, empty, push, pop;
   logic [CW-1:0] count;
   state_e state_q, state_d;
   logic err_q, err_d;
   logic [2:0] cnt_q, cnt_d;
   logic mem_en_q, mem_en_d, mem_we_q, mem_we_d;
   logic load_valid_q, load_valid_d, store_done_q, store_done_d, misalign_err_q, misalign_err_d;
   logic [3:0] mem_wstrb_q, mem_wstrb_d;
   logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, load_value_q, load_value_d;
   logic [5:0] load_rd_tag_q, load_rd_tag_d, load_rob_index_q, load_rob_index_d;
   logic [5:0] store_rob_index_q, store_rob_index_d, err_rob_index_q, err_rob_index_d;

   assign req         = {req_is_load_i, req_byte_i, req_addr_i, req_wdata_i, req_rd_tag_i, req_rob_index_i};
   assign req_ready_o = count < CW'(FIFO_DEPTH);
   assign push        = req_valid_i && !full;

   mem_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  (req),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   // FSM sequencing plus next values of every registered output
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: if (!empty) begin
            pop     = 1'b1;
            op_d    = head;
            err_d   = misaligned(head.is_byte, head.addr[1:0]);
            state_d = err_d ? DONE : ISSUE;
         end
         ISSUE: begin
            state_d = op_q.is_load ? WAIT : DONE;
            cnt_d   = 3'(MEM_LATENCY);
         end
         WAIT: begin
            cnt_d   = cnt_q - 3'd1;
            state_d = cnt_q == 3'd1 ? DONE : WAIT;
         end
         default: state_d = IDLE;
      endcase
      mem_en_d          = pop && !err_d;
      mem_we_d          = mem_en_d && !head.is_load;
      mem_addr_d        = mem_en_d ? {head.addr[31:2], 2'b00} : '0;
      mem_wstrb_d       = !mem_we_d ? 4'h0 : head.is_byte ? 4'b0001 << head.addr[1:0] : 4'hF;
      mem_wdata_d       = !mem_we_d ? '0 : head.is_byte ? {4{head.wdata[7:0]}} : head.wdata;
      load_valid_d      = state_q == WAIT && cnt_q == 3'd1;
      load_value_d      = load_valid_d ? load_extract(mem_rdata_i, op_q.addr[1:0], op_q.is_byte) : '0;
      load_rd_tag_d     = load_valid_d ? op_q.rd_tag : '0;
      load_rob_index_d  = load_valid_d ? op_q.rob_index : '0;
      store_done_d      = state_q == ISSUE && !op_q.is_load;
      store_rob_index_d = store_done_d ? op_q.rob_index : '0;
      misalign_err_d    = state_q == DONE && err_q;
      err_rob_index_d   = misalign_err_d ? op_q.rob_index : '0;
   end

   // state and output registers, all cleared asynchronously
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q           <= IDLE;
         op_q              <= '0;
         err_q             <= 1'b0;
         cnt_q             <= '0;
         mem_en_q          <= 1'b0;
         mem_we_q          <= 1'b0;
         mem_wstrb_q       <= '0;
         mem_addr_q        <= '0;
         mem_wdata_q       <= '0;
         load_valid_q      <= 1'b0;
         load_value_q      <= '0;
         load_rd_tag_q     <= '0;
         load_rob_index_q  <= '0;
         store_done_q      <= 1'b0;
         store_rob_index_q <= '0;
         misalign_err_q    <= 1'b0;
         err_rob_index_q   <= '0;
      end else begin
         state_q           <= state_d;
         op_q              <= op_d;
         err_q             <= err_d;
         cnt_q             <= cnt_d;
         mem_en_q          <= mem_en_d;
         mem_we_q          <= mem_we_d;
         mem_wstrb_q       <= mem_wstrb_d;
         mem_addr_q        <= mem_addr_d;
         mem_wdata_q       <= mem_wdata_d;
         load_valid_q      <= load_valid_d;
         load_value_q      <= load_value_d;
         load_rd_tag_q     <= load_rd_tag_d;
         load_rob_index_q  <= load_rob_index_d;
         store_done_q      <= store_done_d;
         store_rob_index_q <= store_rob_index_d;
         misalign_err_q    <= misalign_err_d;
         err_rob_index_q   <= err_rob_index_d;
      end

   assign mem_en_o          = mem_en_q;
   assign mem_we_o          = mem_we_q;
   assign mem_wstrb_o       = mem_wstrb_q;
   assign mem_addr_o        = mem_addr_q;
   assign mem_wdata_o       = mem_wdata_q;
   assign load_valid_o      = load_valid_q;
   assign load_value_o      = load_value_q;
   assign load_rd_tag_o     = load_rd_tag_q;
   assign load_rob_index_o  = load_rob_index_q;
   assign store_done_o      = store_done_q;
   assign store_rob_index_o = store_rob_index_q;
   assign misalign_err_o    = misalign_err_q;
   assign err_rob_index_o   = err_rob_index_q;
endmodule
